// File: rtl/conv_run_sequencer_if.sv
// Host/core signal bundle for conv_run_sequencer.
// The slave modport is the sequencer's view; master is the host + core side.
interface conv_run_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    // Host request side
    logic                  host_go;
    logic                  host_clear;
    logic [ADDR_WIDTH-1:0] host_sizeX;
    logic [ADDR_WIDTH-1:0] host_sizeY;

    // Core control side
    logic [DATA_WIDTH-1:0] cfg_o;
    logic                  core_start_o;
    logic                  core_busy_i;
    logic                  core_done_i;
    logic                  mem_host_sel_o;

    // Host status side
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [1:0]            err_code_o;
    logic [CNT_WIDTH-1:0]  cycle_cnt_o;
    logic [ADDR_WIDTH:0]   result_len_o;

    modport slave (
        input  host_go, host_clear, host_sizeX, host_sizeY, core_busy_i, core_done_i,
        output cfg_o, core_start_o, mem_host_sel_o, busy_o, done_o, err_o,
               err_code_o, cycle_cnt_o, result_len_o
    );

    modport master (
        output host_go, host_clear, host_sizeX, host_sizeY, core_busy_i, core_done_i,
        input  cfg_o, core_start_o, mem_host_sel_o, busy_o, done_o, err_o,
               err_code_o, cycle_cnt_o, result_len_o
    );
endinterface

// File: rtl/conv_run_sequencer.sv
// conv_run_sequencer: runs one convolution on the core per accepted host_go.
// Latches sizes into the core config word, pulses start, supervises busy/done,
// swaps memory ownership between host and core and reports sticky status.
// Optional run watchdog: define CONV_SEQ_WDOG_EN to abort a run whose cycle
// count reaches RUN_LIMIT without core_done_i (error code 11).
// All outputs are registered and take their new value on entry to a state,
// so done_o follows core_done_i by exactly one cycle.
module conv_run_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int BUSY_WAIT  = 4,
    parameter int RUN_LIMIT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_run_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        WAIT_BUSY,
        RUN,
        FINISH
    } stateT;

    localparam int TMR_W = $clog2(BUSY_WAIT + 1);
    localparam logic [TMR_W-1:0]      TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0]      TMR_LAST   = TMR_W'(BUSY_WAIT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [1:0]            ERR_SIZE   = 2'b01;
    localparam logic [1:0]            ERR_NOBUSY = 2'b10;
`ifdef CONV_SEQ_WDOG_EN
    localparam logic [1:0]            ERR_WDOG   = 2'b11;
    localparam logic [CNT_WIDTH-1:0]  RUN_LIMIT_CNT = CNT_WIDTH'(RUN_LIMIT);
`endif

    stateT                 stateReg, stateNext;
    logic [DATA_WIDTH-1:0] cfgReg, cfgNext;
    logic                  startReg, startNext;
    logic                  memHostSelReg, memHostSelNext;
    logic                  busyReg, busyNext;
    logic                  doneReg, doneNext;
    logic                  errReg, errNext;
    logic [1:0]            errCodeReg, errCodeNext;
    logic [CNT_WIDTH-1:0]  cycleCntReg, cycleCntNext;
    logic [ADDR_WIDTH:0]   resultLenReg, resultLenNext;
    logic [TMR_W-1:0]      timerReg, timerNext;

    logic [DATA_WIDTH-1:0] cfgWord;
    logic [ADDR_WIDTH:0]   lenSum;
    logic                  sizeBad;
    logic [CNT_WIDTH-1:0]  cntInc;

    // Config word: sizeX in the low field, sizeY above it, the rest zero.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_cfgFields
            assign cfgWord[gi]              = bus.host_sizeX[gi];
            assign cfgWord[ADDR_WIDTH + gi] = bus.host_sizeY[gi];
        end
        for (gi = 2 * ADDR_WIDTH; gi < DATA_WIDTH; gi++) begin : g_cfgPad
            assign cfgWord[gi] = 1'b0;
        end
    endgenerate

    // One extra bit on the sum so (31,31) -> 61 does not wrap.
    assign lenSum  = {1'b0, bus.host_sizeX} + {1'b0, bus.host_sizeY} - LEN_ONE;
    assign sizeBad = (bus.host_sizeX == '0) || (bus.host_sizeY == '0);
    // Run counter saturates rather than wrapping.
    assign cntInc  = (cycleCntReg == '1) ? cycleCntReg : cycleCntReg + CNT_ONE;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        stateNext      = stateReg;
        cfgNext        = cfgReg;
        startNext      = 1'b0;
        memHostSelNext = memHostSelReg;
        busyNext       = busyReg;
        doneNext       = doneReg;
        errNext        = errReg;
        errCodeNext    = errCodeReg;
        cycleCntNext   = cycleCntReg;
        resultLenNext  = resultLenReg;
        timerNext      = timerReg;

        // Clear acts first so a same-cycle event can still set a fresh flag.
        if (bus.host_clear) begin
            doneNext    = 1'b0;
            errNext     = 1'b0;
            errCodeNext = 2'b00;
        end

        case (stateReg)
            IDLE: begin
                if (bus.host_go) begin
                    if (sizeBad) begin
                        errNext     = 1'b1;
                        errCodeNext = ERR_SIZE;
                    end else begin
                        cfgNext        = cfgWord;
                        resultLenNext  = lenSum;
                        doneNext       = 1'b0;
                        errNext        = 1'b0;
                        errCodeNext    = 2'b00;
                        cycleCntNext   = '0;
                        busyNext       = 1'b1;
                        memHostSelNext = 1'b0;
                        stateNext      = ARM;
                    end
                end
            end
            ARM: begin
                // cfg_o has been stable for a full cycle when start rises.
                startNext = 1'b1;
                stateNext = START;
            end
            START: begin
                cycleCntNext = cntInc;
                timerNext    = '0;
                stateNext    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.core_busy_i) begin
                    cycleCntNext = cntInc;
                    stateNext    = RUN;
                end else if (bus.core_done_i) begin
                    doneNext       = 1'b1;
                    busyNext       = 1'b0;
                    memHostSelNext = 1'b1;
                    stateNext      = FINISH;
                end else if (timerReg == TMR_LAST) begin
                    errNext        = 1'b1;
                    errCodeNext    = ERR_NOBUSY;
                    busyNext       = 1'b0;
                    memHostSelNext = 1'b1;
                    stateNext      = FINISH;
                end else begin
                    cycleCntNext = cntInc;
                    timerNext    = timerReg + TMR_ONE;
                end
            end
            RUN: begin
                if (bus.core_done_i) begin
                    doneNext       = 1'b1;
                    busyNext       = 1'b0;
                    memHostSelNext = 1'b1;
                    stateNext      = FINISH;
`ifdef CONV_SEQ_WDOG_EN
                end else if (cycleCntReg >= RUN_LIMIT_CNT) begin
                    errNext        = 1'b1;
                    errCodeNext    = ERR_WDOG;
                    busyNext       = 1'b0;
                    memHostSelNext = 1'b1;
                    stateNext      = FINISH;
`endif
                end else begin
                    cycleCntNext = cntInc;
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Registered outputs and run bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfgReg        <= '0;
            startReg      <= 1'b0;
            memHostSelReg <= 1'b1;
            busyReg       <= 1'b0;
            doneReg       <= 1'b0;
            errReg        <= 1'b0;
            errCodeReg    <= 2'b00;
            cycleCntReg   <= '0;
            resultLenReg  <= '0;
            timerReg      <= '0;
        end else begin
            cfgReg        <= cfgNext;
            startReg      <= startNext;
            memHostSelReg <= memHostSelNext;
            busyReg       <= busyNext;
            doneReg       <= doneNext;
            errReg        <= errNext;
            errCodeReg    <= errCodeNext;
            cycleCntReg   <= cycleCntNext;
            resultLenReg  <= resultLenNext;
            timerReg      <= timerNext;
        end
    end

    assign bus.cfg_o          = cfgReg;
    assign bus.core_start_o   = startReg;
    assign bus.mem_host_sel_o = memHostSelReg;
    assign bus.busy_o         = busyReg;
    assign bus.done_o         = doneReg;
    assign bus.err_o          = errReg;
    assign bus.err_code_o     = errCodeReg;
    assign bus.cycle_cnt_o    = cycleCntReg;
    assign bus.result_len_o   = resultLenReg;
endmodule
